// File: rtl/uart_rx_controller.sv
// UART receive sequencer: frames start/data/parity/stop bits using an external
// oversampling edge counter, majority-votes each bit and deserializes LSB-first.
module uart_rx_controller #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic [4:0]            edge_count,
  input  logic                  edge_count_done,
  output logic                  edge_cnt_en,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t                state, next_state;
  logic [5:0]            p_lat;
  logic                  par_en_lat;
  logic                  par_type_lat;
  logic [2:0]            samples;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_err;

  logic       prescale_ok;
  logic       majority;
  logic [5:0] half;
  logic [5:0] edge6;
  logic       at_s0, at_s1, at_s2, at_dec;
  logic       framing;
  logic       start_frame, shift_en, bit_inc, bit_clr, par_chk, stop_dec;

  assign prescale_ok = (prescale == 6'd8) || (prescale == 6'd16) || (prescale == 6'd32);
  assign half        = p_lat >> 1;
  assign edge6       = {1'b0, edge_count};
  assign at_s0       = (edge6 == half - 6'd1);
  assign at_s1       = (edge6 == half);
  assign at_s2       = (edge6 == half + 6'd1);
  assign at_dec      = (edge6 == half + 6'd2);
  assign majority    = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);
  assign framing     = (state != IDLE) && (state != BREAK);
  assign busy        = framing;
  assign edge_cnt_en = framing;

  always_ff @(posedge UCLK) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    bit_inc     = 1'b0;
    bit_clr     = 1'b0;
    par_chk     = 1'b0;
    stop_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_in && prescale_ok) begin
          next_state  = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (at_dec && majority) begin
          next_state = IDLE;
        end else if (edge_count_done) begin
          next_state = DATA;
          bit_clr    = 1'b1;
        end
      end
      DATA: begin
        shift_en = at_dec;
        if (edge_count_done) begin
          if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) next_state = par_en_lat ? PARITY : STOP;
          else                                   bit_inc    = 1'b1;
        end
      end
      PARITY: begin
        par_chk = at_dec;
        if (edge_count_done) next_state = STOP;
      end
      // Leave at mid-stop-bit so a following start edge is not missed.
      STOP: begin
        if (at_dec) begin
          stop_dec   = 1'b1;
          next_state = majority ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_in) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge UCLK) begin
    if (reset) begin
      p_lat         <= '0;
      par_en_lat    <= 1'b0;
      par_type_lat  <= 1'b0;
      samples       <= '0;
      shift_reg     <= '0;
      bit_cnt       <= '0;
      par_err       <= 1'b0;
      p_data        <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      if (start_frame) begin
        p_lat        <= prescale;
        par_en_lat   <= parity_enable;
        par_type_lat <= parity_type;
        par_err      <= 1'b0;
      end
      if (framing) begin
        if (at_s0) samples[0] <= rx_in;
        if (at_s1) samples[1] <= rx_in;
        if (at_s2) samples[2] <= rx_in;
      end
      if (shift_en) shift_reg <= {majority, shift_reg[DATA_WIDTH-1:1]};
      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;
      if (par_chk) par_err <= majority ^ (^shift_reg) ^ par_type_lat;
      if (stop_dec) begin
        if (majority && !par_err) begin
          p_data     <= shift_reg;
          data_valid <= 1'b1;
        end else if (majority) begin
          parity_error <= 1'b1;
        end else begin
          framing_error <= 1'b1;
          parity_error  <= par_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller with an edge-counter stub and a
// frame-level reference model (expected byte, outcome and pulse cycle).
module tb_uart_rx_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       parity_enable = 1'b0;
  logic       parity_type = 1'b0;
  logic [4:0] edge_count;
  logic       edge_count_done;
  logic       edge_cnt_en;
  logic [7:0] p_data;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  int cyc = 0;
  int cnt_p = 8;
  int cmp_cnt = 0;
  int fail_cnt = 0;
  int dv_cnt = 0, pe_cnt = 0, fe_cnt = 0;
  int dv_last = -1, pe_last = -1, fe_last = -1;
  int overlap_cnt = 0, pdata_bad = 0;
  int rise_cyc = -1, fall_cyc = -1;
  logic       prev_busy = 1'b0;
  logic       rst_seen = 1'b1;
  logic [7:0] prev_pdata = 8'h00;
  logic [7:0] exp_pdata = 8'h00;
  logic [4:0] ecnt = 5'd0;

  uart_rx_controller #(.DATA_WIDTH(8)) dut (
    .UCLK(clk), .reset(reset), .rx_in(rx_in), .prescale(prescale),
    .parity_enable(parity_enable), .parity_type(parity_type),
    .edge_count(edge_count), .edge_count_done(edge_count_done),
    .edge_cnt_en(edge_cnt_en), .p_data(p_data), .data_valid(data_valid),
    .parity_error(parity_error), .framing_error(framing_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge counter running at the transmitter's bit rate (cnt_p).
  always @(posedge clk) begin
    if (reset || !edge_cnt_en)       ecnt <= 5'd0;
    else if (int'(ecnt) == cnt_p - 1) ecnt <= 5'd0;
    else                              ecnt <= ecnt + 5'd1;
  end
  assign edge_count      = ecnt;
  assign edge_count_done = (int'(ecnt) == cnt_p - 1);

  always @(negedge clk) begin
    if (data_valid)    begin dv_cnt++; dv_last = cyc; end
    if (parity_error)  begin pe_cnt++; pe_last = cyc; end
    if (framing_error) begin fe_cnt++; fe_last = cyc; end
    if (data_valid && (parity_error || framing_error)) overlap_cnt++;
    if (!rst_seen && !data_valid && p_data !== prev_pdata) pdata_bad++;
    if (busy === 1'b1 && prev_busy === 1'b0) rise_cyc = cyc;
    if (busy === 1'b0 && prev_busy === 1'b1) fall_cyc = cyc;
    prev_busy  = busy;
    prev_pdata = p_data;
    rst_seen   = reset;
  end

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int exp_cyc(input int t, input int p, input logic pen);
    return t + 2 + (pen ? 10 : 9) * p + p / 2 + 2;
  endfunction

  // Drives one frame, P cycles per bit, starting in the current cycle (t).
  task automatic drive_frame(input logic [7:0] data, input int p, input logic pen,
                             input logic ptype, input logic bad_par, input logic stop,
                             input int chg_p, input int abort_at, output int t);
    logic bits [0:10];
    int   nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    nb = 9;
    if (pen) begin
      bits[9] = (^data) ^ ptype ^ bad_par;
      nb = 10;
    end
    bits[nb] = stop;
    nb++;
    cnt_p = p;
    prescale = 6'(p);
    parity_enable = pen;
    parity_type = ptype;
    t = cyc;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < p; c++) begin
        if (abort_at >= 0 && k * p + c == abort_at + 1) begin
          reset = 1'b0;
          rx_in = 1'b1;
          return;
        end
        reset = (k * p + c == abort_at);
        if (chg_p != 0 && c == 0 && k == 4) begin
          prescale = 6'(chg_p);
          parity_enable = ~pen;
          parity_type = ~ptype;
        end
        if (chg_p != 0 && c == 0 && k == nb - 1) begin
          prescale = 6'(p);
          parity_enable = pen;
          parity_type = ptype;
        end
        rx_in = bits[k];
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx_in = 1'b1;
    settle(3);
    @(negedge clk);
    cmp_cnt++;
    if ({busy, edge_cnt_en, data_valid, parity_error, framing_error, p_data} !== 13'b0) begin
      fail_cnt++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {busy, edge_cnt_en, data_valid, parity_error, framing_error, p_data});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    settle(2);
  endtask

  task automatic test_basic_frame;
    int t, dv0, pe0, fe0;
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    drive_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, t);
    settle(4);
    exp_pdata = 8'hA5;
    cmp_cnt++;
    if (dv_cnt - dv0 != 1 || dv_last - t != 80) begin
      fail_cnt++;
      $display("FAIL basic_dv: %0d pulses, last at t+%0d; expected 1 at t+80", dv_cnt - dv0, dv_last - t);
    end
    cmp_cnt++;
    if (p_data !== 8'hA5) begin
      fail_cnt++;
      $display("FAIL basic_pdata: got %h expected a5", p_data);
    end
    cmp_cnt++;
    if (pe_cnt != pe0 || fe_cnt != fe0) begin
      fail_cnt++;
      $display("FAIL basic_errors: pe %0d fe %0d, expected 0 0", pe_cnt - pe0, fe_cnt - fe0);
    end
    cmp_cnt++;
    if (rise_cyc - t != 1 || fall_cyc - t != 80) begin
      fail_cnt++;
      $display("FAIL basic_busy: high t+%0d..low at t+%0d, expected t+1..low at t+80",
               rise_cyc - t, fall_cyc - t);
    end
  endtask

  task automatic test_parity;
    int t, dv0, pe0, fe0;
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    drive_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 0, -1, t);
    settle(4);
    exp_pdata = 8'h3C;
    cmp_cnt++;
    if (dv_cnt - dv0 != 1 || dv_last - t != 172 || pe_cnt != pe0 || p_data !== 8'h3C) begin
      fail_cnt++;
      $display("FAIL parity_good: dv %0d at t+%0d pe %0d data %h, expected dv 1 at t+172 pe 0 data 3c",
               dv_cnt - dv0, dv_last - t, pe_cnt - pe0, p_data);
    end
    dv0 = dv_cnt; pe0 = pe_cnt;
    drive_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 0, -1, t);
    settle(4);
    cmp_cnt++;
    if (pe_cnt - pe0 != 1 || pe_last - t != 172 || dv_cnt != dv0 || fe_cnt != fe0) begin
      fail_cnt++;
      $display("FAIL parity_bad: pe %0d at t+%0d dv %0d fe %0d, expected pe 1 at t+172 dv 0 fe 0",
               pe_cnt - pe0, pe_last - t, dv_cnt - dv0, fe_cnt - fe0);
    end
    cmp_cnt++;
    if (p_data !== 8'h3C) begin
      fail_cnt++;
      $display("FAIL parity_hold: got %h expected 3c", p_data);
    end
  endtask

  task automatic test_glitch;
    int t, dv0, pe0, fe0;
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    prescale = 6'd8;
    cnt_p = 8;
    t = cyc;
    rx_in = 1'b0;
    settle(3);
    rx_in = 1'b1;
    settle(12);
    cmp_cnt++;
    if (rise_cyc - t != 1 || fall_cyc - t != 8) begin
      fail_cnt++;
      $display("FAIL glitch_busy: rise t+%0d fall t+%0d, expected t+1 and t+8", rise_cyc - t, fall_cyc - t);
    end
    cmp_cnt++;
    if (dv_cnt != dv0 || pe_cnt != pe0 || fe_cnt != fe0 || {busy, edge_cnt_en} !== 2'b00) begin
      fail_cnt++;
      $display("FAIL glitch_quiet: dv %0d pe %0d fe %0d busy/en %b, expected 0 0 0 00",
               dv_cnt - dv0, pe_cnt - pe0, fe_cnt - fe0, {busy, edge_cnt_en});
    end
  endtask

  task automatic test_break;
    int t, t2, dv0, pe0, fe0;
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    drive_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, t);
    settle(100);
    cmp_cnt++;
    if (fe_cnt - fe0 != 1 || fe_last - t != 80 || dv_cnt != dv0 || pe_cnt != pe0) begin
      fail_cnt++;
      $display("FAIL break_framing: fe %0d at t+%0d dv %0d pe %0d, expected fe 1 at t+80 dv 0 pe 0",
               fe_cnt - fe0, fe_last - t, dv_cnt - dv0, pe_cnt - pe0);
    end
    cmp_cnt++;
    if (rise_cyc - t != 1 || busy !== 1'b0) begin
      fail_cnt++;
      $display("FAIL break_hold: last rise t+%0d busy %b, expected rise t+1 busy 0", rise_cyc - t, busy);
    end
    rx_in = 1'b1;
    settle(3);
    dv0 = dv_cnt;
    drive_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, t2);
    settle(4);
    exp_pdata = 8'h55;
    cmp_cnt++;
    if (dv_cnt - dv0 != 1 || dv_last - t2 != 80 || p_data !== 8'h55) begin
      fail_cnt++;
      $display("FAIL break_recover: dv %0d at t+%0d data %h, expected 1 at t+80 data 55",
               dv_cnt - dv0, dv_last - t2, p_data);
    end
  endtask

  task automatic test_illegal_prescale;
    int bad, r0;
    bad = 0;
    r0 = rise_cyc;
    prescale = 6'd12;
    cnt_p = 12;
    for (int i = 0; i < 60; i++) begin
      rx_in = 1'($urandom);
      @(negedge clk);
      if (busy !== 1'b0 || edge_cnt_en !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    rx_in = 1'b1;
    prescale = 6'd8;
    cnt_p = 8;
    settle(2);
    cmp_cnt++;
    if (bad != 0 || rise_cyc != r0) begin
      fail_cnt++;
      $display("FAIL illegal_prescale: %0d busy cycles, expected 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    int t1, t2, dv0, pe0, fe0;
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    drive_frame(8'h01, 32, 1'b0, 1'b0, 1'b0, 1'b1, 8, -1, t1);
    cmp_cnt++;
    if (dv_cnt - dv0 != 1 || dv_last != exp_cyc(t1, 32, 1'b0) || p_data !== 8'h01) begin
      fail_cnt++;
      $display("FAIL b2b_first: dv %0d at t+%0d data %h, expected 1 at t+%0d data 01",
               dv_cnt - dv0, dv_last - t1, p_data, exp_cyc(t1, 32, 1'b0) - t1);
    end
    drive_frame(8'hFE, 32, 1'b0, 1'b0, 1'b0, 1'b1, 16, -1, t2);
    settle(4);
    exp_pdata = 8'hFE;
    cmp_cnt++;
    if (dv_cnt - dv0 != 2 || dv_last != exp_cyc(t2, 32, 1'b0) || p_data !== 8'hFE) begin
      fail_cnt++;
      $display("FAIL b2b_second: dv %0d at t+%0d data %h, expected 2 total, at t+%0d data fe",
               dv_cnt - dv0, dv_last - t2, p_data, exp_cyc(t2, 32, 1'b0) - t2);
    end
    cmp_cnt++;
    if (pe_cnt != pe0 || fe_cnt != fe0) begin
      fail_cnt++;
      $display("FAIL b2b_errors: pe %0d fe %0d, expected 0 0", pe_cnt - pe0, fe_cnt - fe0);
    end
  endtask

  task automatic test_reset_midframe;
    int t, t2, dv0;
    dv0 = dv_cnt;
    drive_frame(8'hB7, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 44, t);
    @(negedge clk);
    exp_pdata = 8'h00;
    cmp_cnt++;
    if ({busy, edge_cnt_en, data_valid, parity_error, framing_error, p_data} !== 13'b0) begin
      fail_cnt++;
      $display("FAIL midframe_reset: got %b, expected all zero",
               {busy, edge_cnt_en, data_valid, parity_error, framing_error, p_data});
    end
    @(posedge clk); #1;
    settle(2);
    drive_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, t2);
    settle(4);
    exp_pdata = 8'h81;
    cmp_cnt++;
    if (dv_cnt - dv0 != 1 || dv_last - t2 != 80 || p_data !== 8'h81) begin
      fail_cnt++;
      $display("FAIL midframe_next: dv %0d at t+%0d data %h, expected 1 at t+80 data 81",
               dv_cnt - dv0, dv_last - t2, p_data);
    end
  endtask

  task automatic test_random;
    int t, p, dv0, pe0, fe0, ecyc, ocyc;
    logic pen, ptype, bad, stop;
    logic [7:0] data;
    logic [2:0] got, want;
    for (int n = 0; n < 12; n++) begin
      p     = 8 << $urandom_range(0, 2);
      pen   = 1'($urandom);
      ptype = 1'($urandom);
      bad   = pen & ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 4) != 0);
      data  = 8'($urandom);
      dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
      drive_frame(data, p, pen, ptype, bad, stop, 0, -1, t);
      rx_in = 1'b1;
      settle(3);
      want = {stop & ~bad, bad, ~stop};
      if (stop && !bad) exp_pdata = data;
      ecyc = exp_cyc(t, p, pen);
      got  = {dv_cnt - dv0 == 1, pe_cnt - pe0 == 1, fe_cnt - fe0 == 1};
      cmp_cnt++;
      if (got !== want || dv_cnt - dv0 > 1 || pe_cnt - pe0 > 1 || fe_cnt - fe0 > 1) begin
        fail_cnt++;
        $display("FAIL rand_outcome[%0d]: dv/pe/fe %0d/%0d/%0d, expected %b (P=%0d par=%b data=%h)",
                 n, dv_cnt - dv0, pe_cnt - pe0, fe_cnt - fe0, want, p, pen, data);
      end
      ocyc = !stop ? fe_last : (bad ? pe_last : dv_last);
      cmp_cnt++;
      if (ocyc != ecyc) begin
        fail_cnt++;
        $display("FAIL rand_timing[%0d]: pulse at t+%0d, expected t+%0d", n, ocyc - t, ecyc - t);
      end
      cmp_cnt++;
      if (p_data !== exp_pdata) begin
        fail_cnt++;
        $display("FAIL rand_pdata[%0d]: got %h expected %h", n, p_data, exp_pdata);
      end
    end
  endtask

  task automatic test_invariants;
    cmp_cnt++;
    if (overlap_cnt != 0 || pdata_bad != 0) begin
      fail_cnt++;
      $display("FAIL invariants: valid+error overlaps %0d, unflagged p_data changes %0d, expected 0 0",
               overlap_cnt, pdata_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    settle(5);
    test_parity();
    settle(5);
    test_glitch();
    test_break();
    settle(5);
    test_illegal_prescale();
    test_back_to_back();
    settle(5);
    test_reset_midframe();
    settle(5);
    test_random();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
